rggen_register_multicycle: RTL and testbench
============================================

RGGEN_REGISTER_MULTICYCLE -- requirements
Module: rggen_register_multicycle

Interface
REQ-001 SHALL take parameter READABLE, default 1'b1, register readable.
REQ-002 SHALL take parameter WRITABLE, default 1'b1, register writable.
REQ-003 SHALL take parameter ADDRESS_WIDTH, default 8, bus address width.
REQ-004 SHALL take parameter OFFSET_ADDRESS, default all-zero, byte address of word 0.
REQ-005 SHALL take parameter BUS_WIDTH, default 32, bus data width (multiple of 8).
REQ-006 SHALL take parameter DATA_WIDTH, default BUS_WIDTH, register width (multiple of BUS_WIDTH; WORDS = DATA_WIDTH/BUS_WIDTH).
REQ-007 SHALL take parameter WAIT_CYCLES, default 0, range 0..15, wait states before bit-field issue.
REQ-008 SHALL take parameter ERROR_ON_DENIED, default 0, 1 = error response on disallowed-direction hit.
REQ-009 SHALL take parameter TIMEOUT_CYCLES, default 16, range 1..255, bit-field ready timeout.
REQ-010 SHALL have ports (one clock; reset is synchronous and active-high): i_clk in 1 clock; i_rst in 1 reset; i_register_valid in 1; i_register_access in 2 (bit0 = write); i_register_address in ADDRESS_WIDTH; i_register_write_data in BUS_WIDTH; i_register_strobe in BUS_WIDTH/8; o_register_active out 1; o_register_ready out 1; o_register_status out 2; o_register_read_data out BUS_WIDTH; o_register_value out DATA_WIDTH; i_additional_match in 1; o_bit_field_valid out 1; o_bit_field_read_mask out DATA_WIDTH; o_bit_field_write_mask out DATA_WIDTH; o_bit_field_write_data out DATA_WIDTH; i_bit_field_ready in 1; i_bit_field_read_data in DATA_WIDTH; i_bit_field_value in DATA_WIDTH.

Function
REQ-011 Word hit SHALL mean address in [OFFSET_ADDRESS + k*BUS_WIDTH/8, +BUS_WIDTH/8) for word k, and i_additional_match high.
REQ-012 o_register_active SHALL be combinational: hit and (direction permitted, or ERROR_ON_DENIED=1).
REQ-013 FSM states SHALL be IDLE, WAIT, ISSUE, RESPOND.
REQ-014 IDLE: i_register_valid and o_register_active SHALL capture word index, masks (byte strobe per word, read mask all bytes of hit word), write data replicated WORDS times; next WAIT if WAIT_CYCLES>0, else ISSUE; denied hit goes to RESPOND with error flag.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles (4-bit down-counter), then ISSUE.
REQ-016 ISSUE SHALL drive o_bit_field_valid=1 with captured masks/data until i_bit_field_ready=1; in that cycle capture hit word of i_bit_field_read_data, go RESPOND.
REQ-017 RESPOND SHALL assert o_register_ready for exactly one cycle with captured read data (zero for writes/errors) and status (00 OK, 10 error); next IDLE.
REQ-018 Minimum latency, ready immediate: o_register_ready at acceptance cycle + WAIT_CYCLES + 2.
REQ-019 No new acceptance in WAIT/ISSUE/RESPOND; back-to-back requests SHALL see one IDLE cycle between.
REQ-020 Deassertion of i_register_valid after acceptance SHALL NOT abort the transaction.
REQ-021 Outside ISSUE, o_bit_field_valid and all masks SHALL be zero.
REQ-022 o_register_value SHALL equal i_bit_field_value combinationally.
REQ-023 With ERROR_ON_DENIED=0 a disallowed-direction hit SHALL be ignored (active low, no response).

Reset
REQ-024 i_rst high at a rising edge SHALL force IDLE and zero counters, captured data, o_register_ready, o_register_status, o_register_read_data, o_bit_field_valid, masks, write data.
REQ-025 Reset mid-transaction SHALL discard it with no ready issued.

Configuration
REQ-026 With RGGEN_REGISTER_TIMEOUT_EN defined, an 8-bit counter in ISSUE SHALL abort after TIMEOUT_CYCLES cycles without ready: valid drops, RESPOND with status 10, read data zero.
REQ-027 Without RGGEN_REGISTER_TIMEOUT_EN, ISSUE SHALL wait indefinitely and no timeout counter SHALL exist.

Verification
REQ-028 BUS 32, DATA 64, OFFSET 0x10, WAIT 2, ready tied 1: write 0x10 strobe 0xF data 0xA5A5A5A5 -> write_mask 0x00000000_FFFFFFFF, ready 4 cycles after acceptance, status 00.
REQ-029 Same config: read 0x14 with read_data 0x12345678_9ABCDEF0 -> o_register_read_data 0x12345678, status 00.
REQ-030 WRITABLE 0, ERROR_ON_DENIED 1: write 0x10 -> no bit_field_valid, ready 1 cycle after acceptance, status 10; with ERROR_ON_DENIED 0 -> active 0, no ready.
REQ-031 TIMEOUT_EN defined, TIMEOUT 4, ready held 0 -> valid high 4 cycles, then ready, status 10, read data 0; undefined -> no ready after 100 cycles.
REQ-032 i_rst pulsed during WAIT -> no ready; next read completes normally with status 00.

Source files
------------

// File: rtl/rggen_register_multicycle.sv
// rggen_register_multicycle
//   Multi-word register front end with configurable wait states. A bus
//   request that hits one of the register's WORDS bus-sized words is
//   captured. After WAIT_CYCLES wait states it is issued to the bit fields,
//   and the register answers with a one-cycle o_register_ready pulse.
//   A hit in a direction the register does not allow returns an error when
//   ERROR_ON_DENIED is set. Otherwise such a hit is ignored.
//
//   Optional feature macro: RGGEN_REGISTER_TIMEOUT_EN. When it is defined,
//   an issued access that sees no i_bit_field_ready within TIMEOUT_CYCLES
//   cycles is aborted with an error status.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_register_valid/access/address/write_data/strobe   bus request
//   o_register_active            combinational hit indication
//   o_register_ready/status/read_data                   bus response (registered)
//   o_register_value             bit-field value passthrough
//   i_additional_match           extra qualifier for the address hit
//   o_bit_field_valid/read_mask/write_mask/write_data   bit-field request
//   i_bit_field_ready/read_data/value                   bit-field response
module rggen_register_multicycle #(
    parameter bit                     READABLE        = 1'b1,
    parameter bit                     WRITABLE        = 1'b1,
    parameter int                     ADDRESS_WIDTH   = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = {ADDRESS_WIDTH{1'b0}},
    parameter int                     BUS_WIDTH       = 32,
    parameter int                     DATA_WIDTH      = BUS_WIDTH,
    parameter int                     WAIT_CYCLES     = 0,
    parameter bit                     ERROR_ON_DENIED = 1'b0,
    parameter int                     TIMEOUT_CYCLES  = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_register_strobe,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic [DATA_WIDTH-1:0]    o_register_value,
    input  logic                     i_additional_match,
    output logic                     o_bit_field_valid,
    output logic [DATA_WIDTH-1:0]    o_bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
    input  logic                     i_bit_field_ready,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_value
);

    localparam int BYTES = BUS_WIDTH / 8;
    localparam int WORDS = DATA_WIDTH / BUS_WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int AW1   = ADDRESS_WIDTH + 1;
    localparam logic [AW1-1:0] BASE_EXT = {1'b0, OFFSET_ADDRESS};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_s;
    logic [3:0]              wait_cnt_r;
    logic [IDX_W-1:0]        word_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   cap_rmask_r;
    logic [DATA_WIDTH-1:0]   cap_wmask_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [BUS_WIDTH-1:0]    rdata_r;
    logic [1:0]              status_r;
    logic                    ready_r;
    logic                    bf_valid_r;
    logic [DATA_WIDTH-1:0]   bf_rmask_r;
    logic [DATA_WIDTH-1:0]   bf_wmask_r;

    logic                    hit_s;
    logic [IDX_W-1:0]        word_s;
    logic                    is_write_s;
    logic                    permit_s;
    logic                    denied_s;
    logic                    accept_s;
    logic                    timeout_s;
    logic                    resp_err_s;
    logic [DATA_WIDTH-1:0]   rmask_s;
    logic [DATA_WIDTH-1:0]   wmask_s;
    logic [BUS_WIDTH-1:0]    rd_word_s;
    logic [AW1-1:0]          addr_ext_s;
    logic                    unused_s;

    // Only bit 0 of the access code (write) matters here.
    assign unused_s = i_register_access[1] ^ (TIMEOUT_CYCLES > 0);

    assign addr_ext_s        = {1'b0, i_register_address};
    assign is_write_s        = i_register_access[0];
    assign permit_s          = is_write_s ? WRITABLE : READABLE;
    assign denied_s          = hit_s & ~permit_s;
    assign o_register_active = hit_s & (permit_s | ERROR_ON_DENIED);
    assign accept_s          = (state_r == ST_IDLE) & i_register_valid & o_register_active;
    assign o_register_value  = i_bit_field_value;

    // Address decode: find which word (if any) the request falls into.
    always_comb begin
        hit_s  = 1'b0;
        word_s = {IDX_W{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            if ((addr_ext_s >= (BASE_EXT + AW1'(k * BYTES))) &&
                (addr_ext_s <  (BASE_EXT + AW1'((k + 1) * BYTES)))) begin
                hit_s  = 1'b1;
                word_s = IDX_W'(k);
            end else begin
                hit_s  = hit_s;
            end
        end
        hit_s = hit_s & i_additional_match;
    end

    // Request masks: byte strobes for a write and the whole word for a read, hit word only.
    always_comb begin
        rmask_s = {DATA_WIDTH{1'b0}};
        wmask_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            for (int b = 0; b < BYTES; b++) begin
                rmask_s[k*BUS_WIDTH+b*8 +: 8] =
                    {8{(word_s == IDX_W'(k)) & ~is_write_s & permit_s}};
                wmask_s[k*BUS_WIDTH+b*8 +: 8] =
                    {8{(word_s == IDX_W'(k)) & is_write_s & permit_s & i_register_strobe[b]}};
            end
        end
    end

    // Select the captured word out of the bit-field read data.
    always_comb begin
        rd_word_s = {BUS_WIDTH{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            rd_word_s = (word_r == IDX_W'(k)) ? i_bit_field_read_data[k*BUS_WIDTH +: BUS_WIDTH]
                                              : rd_word_s;
        end
    end

`ifdef RGGEN_REGISTER_TIMEOUT_EN
    logic [7:0] timeout_cnt_r;

    assign timeout_s = (state_r == ST_ISSUE) & ~i_bit_field_ready &
                       (timeout_cnt_r == 8'(TIMEOUT_CYCLES - 1));

    // Count issued cycles without ready; cleared whenever the access is not issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            timeout_cnt_r <= 8'd0;
        end else if ((state_r == ST_ISSUE) && (next_s == ST_ISSUE)) begin
            timeout_cnt_r <= timeout_cnt_r + 8'd1;
        end else begin
            timeout_cnt_r <= 8'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic and error qualification of the response.
    always_comb begin
        next_s     = state_r;
        resp_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (denied_s) begin
                        next_s     = ST_RESPOND;
                        resp_err_s = 1'b1;
                    end else if (WAIT_CYCLES > 0) begin
                        next_s = ST_WAIT;
                    end else begin
                        next_s = ST_ISSUE;
                    end
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    next_s = ST_ISSUE;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (i_bit_field_ready) begin
                    next_s = ST_RESPOND;
                end else if (timeout_s) begin
                    next_s     = ST_RESPOND;
                    resp_err_s = 1'b1;
                end else begin
                    next_s = ST_ISSUE;
                end
            end
            ST_RESPOND: next_s = ST_IDLE;
            default:    next_s = ST_IDLE;
        endcase
    end

    // State register, request capture and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 4'd0;
            word_r      <= {IDX_W{1'b0}};
            write_r     <= 1'b0;
            cap_rmask_r <= {DATA_WIDTH{1'b0}};
            cap_wmask_r <= {DATA_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            rdata_r     <= {BUS_WIDTH{1'b0}};
            status_r    <= 2'b00;
            ready_r     <= 1'b0;
            bf_valid_r  <= 1'b0;
            bf_rmask_r  <= {DATA_WIDTH{1'b0}};
            bf_wmask_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= next_s;
            if (accept_s) begin
                word_r      <= word_s;
                write_r     <= is_write_s;
                cap_rmask_r <= rmask_s;
                cap_wmask_r <= wmask_s;
                wdata_r     <= {WORDS{i_register_write_data}};
                wait_cnt_r  <= (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            // Masks bypass the capture registers on a zero-wait acceptance.
            bf_valid_r <= (next_s == ST_ISSUE);
            bf_rmask_r <= (next_s != ST_ISSUE) ? {DATA_WIDTH{1'b0}} :
                          accept_s ? rmask_s : cap_rmask_r;
            bf_wmask_r <= (next_s != ST_ISSUE) ? {DATA_WIDTH{1'b0}} :
                          accept_s ? wmask_s : cap_wmask_r;
            ready_r    <= (next_s == ST_RESPOND);
            status_r   <= ((next_s == ST_RESPOND) && resp_err_s) ? 2'b10 : 2'b00;
            rdata_r    <= ((state_r == ST_ISSUE) && i_bit_field_ready && !write_r)
                          ? rd_word_s : {BUS_WIDTH{1'b0}};
        end
    end

    assign o_register_ready       = ready_r;
    assign o_register_status      = status_r;
    assign o_register_read_data   = rdata_r;
    assign o_bit_field_valid      = bf_valid_r;
    assign o_bit_field_read_mask  = bf_rmask_r;
    assign o_bit_field_write_mask = bf_wmask_r;
    assign o_bit_field_write_data = wdata_r;

endmodule

// File: tb/tb_rggen_register_multicycle.sv
// Directed bench for rggen_register_multicycle.
// Instance 0: READ/WRITE, WAIT 2, TIMEOUT 4.
// Instance 1: read-only, error on denied, WAIT 0.
// Instance 2: read-only, denied hits ignored.
// All instances use a 64-bit register on a 32-bit bus at offset 0x10.
module tb_rggen_register_multicycle;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  valid;
    logic [1:0]  access;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        amatch;
    logic        bf_ready;
    logic [63:0] bf_rdata;
    logic [63:0] bf_value;

    logic        active_o [3];
    logic        ready_o  [3];
    logic [1:0]  status_o [3];
    logic [31:0] rdata_o  [3];
    logic [63:0] value_o  [3];
    logic        valid_o  [3];
    logic [63:0] rmask_o  [3];
    logic [63:0] wmask_o  [3];
    logic [63:0] wd_o     [3];

    int n_cmp = 0;
    int n_err = 0;

    rggen_register_multicycle #(
        .READABLE(1'b1), .WRITABLE(1'b1), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10),
        .BUS_WIDTH(32), .DATA_WIDTH(64), .WAIT_CYCLES(2), .ERROR_ON_DENIED(1'b0),
        .TIMEOUT_CYCLES(4)
    ) u_rw (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid[0]), .i_register_access(access),
        .i_register_address(addr), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(active_o[0]), .o_register_ready(ready_o[0]),
        .o_register_status(status_o[0]), .o_register_read_data(rdata_o[0]),
        .o_register_value(value_o[0]), .i_additional_match(amatch),
        .o_bit_field_valid(valid_o[0]), .o_bit_field_read_mask(rmask_o[0]),
        .o_bit_field_write_mask(wmask_o[0]), .o_bit_field_write_data(wd_o[0]),
        .i_bit_field_ready(bf_ready), .i_bit_field_read_data(bf_rdata),
        .i_bit_field_value(bf_value)
    );

    rggen_register_multicycle #(
        .READABLE(1'b1), .WRITABLE(1'b0), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10),
        .BUS_WIDTH(32), .DATA_WIDTH(64), .WAIT_CYCLES(0), .ERROR_ON_DENIED(1'b1),
        .TIMEOUT_CYCLES(4)
    ) u_ro_err (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid[1]), .i_register_access(access),
        .i_register_address(addr), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(active_o[1]), .o_register_ready(ready_o[1]),
        .o_register_status(status_o[1]), .o_register_read_data(rdata_o[1]),
        .o_register_value(value_o[1]), .i_additional_match(amatch),
        .o_bit_field_valid(valid_o[1]), .o_bit_field_read_mask(rmask_o[1]),
        .o_bit_field_write_mask(wmask_o[1]), .o_bit_field_write_data(wd_o[1]),
        .i_bit_field_ready(bf_ready), .i_bit_field_read_data(bf_rdata),
        .i_bit_field_value(bf_value)
    );

    rggen_register_multicycle #(
        .READABLE(1'b1), .WRITABLE(1'b0), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(8'h10),
        .BUS_WIDTH(32), .DATA_WIDTH(64), .WAIT_CYCLES(0), .ERROR_ON_DENIED(1'b0),
        .TIMEOUT_CYCLES(4)
    ) u_ro_ign (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid[2]), .i_register_access(access),
        .i_register_address(addr), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(active_o[2]), .o_register_ready(ready_o[2]),
        .o_register_status(status_o[2]), .o_register_read_data(rdata_o[2]),
        .o_register_value(value_o[2]), .i_additional_match(amatch),
        .o_bit_field_valid(valid_o[2]), .o_bit_field_read_mask(rmask_o[2]),
        .o_bit_field_write_mask(wmask_o[2]), .o_bit_field_write_data(wd_o[2]),
        .i_bit_field_ready(bf_ready), .i_bit_field_read_data(bf_rdata),
        .i_bit_field_value(bf_value)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request to instance inst. Valid drops right after acceptance.
    // Watch up to limit cycles; rdy_cyc = 0 means no ready was seen.
    task automatic run_txn(input int inst, input logic [1:0] acc, input logic [7:0] ad,
                           input logic [3:0] st, input logic [31:0] wd, input int limit,
                           output int rdy_cyc, output int vcnt, output logic [63:0] wm,
                           output logic [63:0] rm, output logic [63:0] wdo,
                           output logic [31:0] rd, output logic [1:0] stat, output int leak);
        @(posedge clk); #1;
        access = acc; addr = ad; strobe = st; wdata = wd; valid[inst] = 1'b1;
        @(posedge clk); #1;
        valid[inst] = 1'b0;
        rdy_cyc = 0; vcnt = 0; wm = '0; rm = '0; wdo = '0; rd = '0; stat = 2'b00; leak = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (valid_o[inst]) begin
                vcnt++; wm = wmask_o[inst]; rm = rmask_o[inst]; wdo = wd_o[inst];
            end else if ((wmask_o[inst] != 64'd0) || (rmask_o[inst] != 64'd0)) begin
                leak++;
            end
            if (ready_o[inst]) begin
                rdy_cyc = c; rd = rdata_o[inst]; stat = status_o[inst];
                break;
            end
        end
    endtask

    int          rc, vc, lk, first_r, second_r, cnt;
    logic [63:0] wm, rm, wdo;
    logic [31:0] rd;
    logic [1:0]  stat;

    initial begin
        rst = 1'b1; valid = 3'b000; access = 2'b00; addr = 8'h00; wdata = 32'd0;
        strobe = 4'h0; amatch = 1'b1; bf_ready = 1'b1; bf_rdata = 64'd0; bf_value = 64'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready",  {63'd0, ready_o[0]},  64'd0);
        check_eq("rst_status", {62'd0, status_o[0]}, 64'd0);
        check_eq("rst_rdata",  {32'd0, rdata_o[0]},  64'd0);
        check_eq("rst_valid",  {63'd0, valid_o[0]},  64'd0);
        check_eq("rst_wdata",  wd_o[0],              64'd0);

        // Value passthrough and combinational address decode.
        bf_value = 64'hDEADBEEF_01234567;
        access = 2'b01; addr = 8'h10; #1;
        check_eq("value", value_o[0], 64'hDEADBEEF_01234567);
        check_eq("act_hit", {63'd0, active_o[0]}, 64'd1);
        addr = 8'h18; #1;
        check_eq("act_above", {63'd0, active_o[0]}, 64'd0);
        addr = 8'h0F; #1;
        check_eq("act_below", {63'd0, active_o[0]}, 64'd0);
        addr = 8'h17; amatch = 1'b0; #1;
        check_eq("act_nomatch", {63'd0, active_o[0]}, 64'd0);
        amatch = 1'b1;

        // Full-word write to word 0.
        run_txn(0, 2'b01, 8'h10, 4'hF, 32'hA5A5A5A5, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("wr0_lat",   rc,  4);
        check_eq("wr0_stat",  {62'd0, stat}, 64'd0);
        check_eq("wr0_wmask", wm,  64'h00000000_FFFFFFFF);
        check_eq("wr0_rmask", rm,  64'd0);
        check_eq("wr0_vcnt",  vc,  1);
        check_eq("wr0_wdata", wdo, 64'hA5A5A5A5_A5A5A5A5);
        check_eq("wr0_rdata", {32'd0, rd}, 64'd0);
        check_eq("wr0_leak",  lk,  0);

        // Partial-strobe write to word 1.
        run_txn(0, 2'b01, 8'h14, 4'b0101, 32'h11223344, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("wr1_lat",   rc,  4);
        check_eq("wr1_wmask", wm,  64'h00FF00FF_00000000);
        check_eq("wr1_wdata", wdo, 64'h11223344_11223344);

        // Reads of both words.
        bf_rdata = 64'h12345678_9ABCDEF0;
        run_txn(0, 2'b00, 8'h14, 4'h0, 32'd0, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("rd1_lat",   rc, 4);
        check_eq("rd1_data",  {32'd0, rd}, 64'h12345678);
        check_eq("rd1_stat",  {62'd0, stat}, 64'd0);
        check_eq("rd1_rmask", rm, 64'hFFFFFFFF_00000000);
        check_eq("rd1_wmask", wm, 64'd0);
        run_txn(0, 2'b00, 8'h10, 4'h0, 32'd0, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("rd0_data",  {32'd0, rd}, 64'h9ABCDEF0);

        // Denied write with an error response, then an allowed zero-wait read.
        run_txn(1, 2'b01, 8'h10, 4'hF, 32'hFFFFFFFF, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("den_lat",  rc, 1);
        check_eq("den_stat", {62'd0, stat}, 64'd2);
        check_eq("den_vcnt", vc, 0);
        check_eq("den_rdata", {32'd0, rd}, 64'd0);
        run_txn(1, 2'b00, 8'h10, 4'h0, 32'd0, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("ro_rd_lat",  rc, 2);
        check_eq("ro_rd_data", {32'd0, rd}, 64'h9ABCDEF0);

        // Denied write ignored.
        @(posedge clk); #1;
        access = 2'b01; addr = 8'h10;
        @(negedge clk);
        check_eq("ign_active", {63'd0, active_o[2]}, 64'd0);
        check_eq("err_active", {63'd0, active_o[1]}, 64'd1);
        run_txn(2, 2'b01, 8'h10, 4'hF, 32'd0, 10, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("ign_ready", rc, 0);
        check_eq("ign_vcnt",  vc, 0);

        // Back-to-back requests with valid held high.
        @(posedge clk); #1;
        access = 2'b00; addr = 8'h14; valid[0] = 1'b1;
        @(posedge clk);
        first_r = 0; second_r = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (ready_o[0]) begin
                if (first_r == 0) first_r = c;
                else if (second_r == 0) begin
                    second_r = c; valid[0] = 1'b0;
                end
            end
        end
        valid[0] = 1'b0;
        check_eq("b2b_first",  first_r,  4);
        check_eq("b2b_second", second_r, 9);

        // Ready withheld by the bit fields.
        bf_ready = 1'b0;
`ifdef RGGEN_REGISTER_TIMEOUT_EN
        run_txn(0, 2'b00, 8'h10, 4'h0, 32'd0, 30, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("to_lat",   rc, 7);
        check_eq("to_vcnt",  vc, 4);
        check_eq("to_stat",  {62'd0, stat}, 64'd2);
        check_eq("to_rdata", {32'd0, rd}, 64'd0);
`else
        run_txn(0, 2'b00, 8'h10, 4'h0, 32'd0, 100, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("nto_ready", rc, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("nto_rst_valid", {63'd0, valid_o[0]}, 64'd0);
`endif
        bf_ready = 1'b1;

        // Reset while waiting discards the access.
        @(posedge clk); #1;
        access = 2'b00; addr = 8'h10; valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready_o[0] || valid_o[0]) cnt++;
        end
        check_eq("rstw_noresp", cnt, 0);
        run_txn(0, 2'b00, 8'h14, 4'h0, 32'd0, 20, rc, vc, wm, rm, wdo, rd, stat, lk);
        check_eq("rstw_lat",  rc, 4);
        check_eq("rstw_data", {32'd0, rd}, 64'h12345678);
        check_eq("rstw_stat", {62'd0, stat}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
